// File: rtl/jtcps1_obj_linebuf.sv
// Object line buffer: two ping-pong banks, read-and-clear readout and a line_start pulse per hs edge.
// Optional build macro JTCPS1_OBJ_FLIP_EN mirrors the readout address when flip=1.
module jtcps1_obj_linebuf #(
  parameter int            AW    = 9,
  parameter logic [AW-1:0] MAXH  = 9'd448,
  parameter logic [8:0]    BLANK = 9'h1FF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic          hs,
  output logic          line_start,
  input  logic [AW-1:0] buf_addr,
  input  logic [8:0]    buf_data,
  input  logic          buf_wr,
  input  logic          flip,
  output logic [8:0]    pxl,
  output logic          busy
);
  localparam logic [AW-1:0] ONE      = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_COL = MAXH - ONE;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          wbank_q, wbank_d;
  logic          hs_l_q;
  logic          line_start_q, line_start_d;
  logic [8:0]    pxl_q, pxl_d;

  logic [8:0]    mem0 [2**AW];
  logic [8:0]    mem1 [2**AW];
  logic          we0, we1;
  logic [AW-1:0] wa0, wa1;
  logic [8:0]    wd0, wd1;
  logic [AW-1:0] rd_addr;
  logic [8:0]    rd_word;
  logic          hs_rise, draw_ok;

`ifdef JTCPS1_OBJ_FLIP_EN
  always_comb begin
    rd_addr = rd_cnt_q;
    if (flip) rd_addr = (rd_cnt_q >= MAXH) ? '0 : LAST_COL - rd_cnt_q;
  end
`else
  logic unused_flip;
  assign unused_flip = flip;
  assign rd_addr     = rd_cnt_q;
`endif

  // The read bank is always the one the draw stage is not writing.
  assign rd_word = wbank_q ? mem0[rd_addr] : mem1[rd_addr];
  assign hs_rise = hs & ~hs_l_q;
  assign draw_ok = buf_wr && (buf_addr < MAXH) && (buf_data[3:0] != 4'hF);

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wbank_d      = wbank_q;
    line_start_d = 1'b0;
    pxl_d        = pxl_q;
    we0 = 1'b0;  wa0 = '0;  wd0 = BLANK;
    we1 = 1'b0;  wa1 = '0;  wd1 = BLANK;
    case (state_q)
      ST_CLEAR: begin
        we0       = 1'b1;
        wa0       = clr_cnt_q;
        we1       = 1'b1;
        wa1       = clr_cnt_q;
        pxl_d     = BLANK;
        clr_cnt_d = clr_cnt_q + ONE;
        if (clr_cnt_q == '1) state_d = ST_RUN;
      end
      default: begin
        if (draw_ok) begin
          if (wbank_q) begin
            we1 = 1'b1;  wa1 = buf_addr;  wd1 = buf_data;
          end else begin
            we0 = 1'b1;  wa0 = buf_addr;  wd0 = buf_data;
          end
        end
        if (pxl_cen) begin
          pxl_d = rd_word;
          if (wbank_q) begin
            we0 = 1'b1;  wa0 = rd_addr;
          end else begin
            we1 = 1'b1;  wa1 = rd_addr;
          end
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + ONE;
        end
        // A new line restarts the read counter even if a pixel was read this clk.
        if (hs_rise) begin
          wbank_d      = ~wbank_q;
          rd_cnt_d     = '0;
          line_start_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
      rd_cnt_q     <= '0;
      wbank_q      <= 1'b0;
      hs_l_q       <= 1'b0;
      line_start_q <= 1'b0;
      pxl_q        <= BLANK;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wbank_q      <= wbank_d;
      hs_l_q       <= hs;
      line_start_q <= line_start_d;
      pxl_q        <= pxl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem0[wa0] <= wd0;
    if (we1) mem1[wa1] <= wd1;
  end

  assign pxl        = pxl_q;
  assign line_start = line_start_q;
  assign busy       = (state_q == ST_CLEAR);
endmodule
